// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: shared constants and helpers for the rgb_pwm_array LED driver.
// Holds the RGB565 field layout, the field-to-duty expansion, the PWM MAX
// helper and the breathing-envelope direction type (used only when
// RGB_PWM_BREATHE_EN is defined).
package rgb_pwm_pkg;

  // RGB565 field layout: R=[15:11], G=[10:5], B=[4:0].
  localparam int R_LSB = 11;
  localparam int R_W   = 5;
  localparam int G_LSB = 5;
  localparam int G_W   = 6;
  localparam int B_LSB = 0;
  localparam int B_W   = 5;

  // Widest supported PWM resolution; expansion results are carried at this width.
  localparam int PWM_W_MAX = 10;

  // Breathing envelope direction.
  typedef enum logic {
    ENV_UP   = 1'b0,
    ENV_DOWN = 1'b1
  } env_dir_e;

  // Largest PWM count for a w-bit counter.
  function automatic int pwm_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Expand a k-bit colour field to w bits: left-justify it, then fill the
  // vacated low (w-k) bits with the field's own top (w-k) bits so that an
  // all-ones field maps to full scale. Valid for 5 <= k <= 6 and 6 <= w <= 10.
  function automatic logic [PWM_W_MAX-1:0] expand_field(input logic [5:0] field,
                                                        input int         k,
                                                        input int         w);
    logic [PWM_W_MAX-1:0] f;
    f = PWM_W_MAX'(field);
    return (f << (w - k)) | (f >> (2 * k - w));
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// rgb_pwm_channel: one RGB LED channel. Holds the pending colour written by
// the port and the active duty triple used by the comparators; active is
// reloaded only when the top asserts load_i, so a colour change never tears
// a PWM period. With RGB_PWM_BREATHE_EN defined the loaded duty can be
// scaled by the global envelope.
module rgb_pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             wr_en_i,
  input  logic [15:0]      wr_color_i,
  input  logic             load_i,
  input  logic [PWM_W-1:0] cnt_i,
`ifdef RGB_PWM_BREATHE_EN
  input  logic             scale_en_i,
  input  logic [PWM_W-1:0] env_i,
`endif
  output logic             r_o,
  output logic             g_o,
  output logic             b_o
);

  logic [15:0]      pending_q;
  logic [PWM_W-1:0] r_duty_q, g_duty_q, b_duty_q;
  logic [PWM_W-1:0] r_duty_d, g_duty_d, b_duty_d;
  logic [PWM_W-1:0] r_exp, g_exp, b_exp;
  logic             r_q, g_q, b_q;

  assign r_exp = PWM_W'(expand_field(6'(pending_q[R_LSB +: R_W]), R_W, PWM_W));
  assign g_exp = PWM_W'(expand_field(6'(pending_q[G_LSB +: G_W]), G_W, PWM_W));
  assign b_exp = PWM_W'(expand_field(6'(pending_q[B_LSB +: B_W]), B_W, PWM_W));

`ifdef RGB_PWM_BREATHE_EN
  // (duty * env) >> PWM_W: full-scale env leaves MAX at MAX-1.
  function automatic logic [PWM_W-1:0] scale(input logic [PWM_W-1:0] d,
                                             input logic [PWM_W-1:0] e);
    logic [2*PWM_W-1:0] p;
    p = (2*PWM_W)'(d) * (2*PWM_W)'(e);
    return p[2*PWM_W-1:PWM_W];
  endfunction
`endif

  // Duty value that will be captured at the next load.
  always_comb begin
    r_duty_d = r_exp;
    g_duty_d = g_exp;
    b_duty_d = b_exp;
`ifdef RGB_PWM_BREATHE_EN
    if (scale_en_i) begin
      r_duty_d = scale(r_exp, env_i);
      g_duty_d = scale(g_exp, env_i);
      b_duty_d = scale(b_exp, env_i);
    end
`endif
  end

  // Pending/active colour registers and the registered comparator outputs.
  // NOTE: every flop uses <=, so the load reads pending as it was before a
  // write in the same cycle; that write therefore lands in the next period.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      r_duty_q  <= '0;
      g_duty_q  <= '0;
      b_duty_q  <= '0;
      r_q       <= 1'b0;
      g_q       <= 1'b0;
      b_q       <= 1'b0;
    end else begin
      if (wr_en_i) pending_q <= wr_color_i;
      if (load_i) begin
        r_duty_q <= r_duty_d;
        g_duty_q <= g_duty_d;
        b_duty_q <= b_duty_d;
      end
      r_q <= enable_i && (cnt_i < r_duty_q);
      g_q <= enable_i && (cnt_i < g_duty_q);
      b_q <= enable_i && (cnt_i < b_duty_q);
    end
  end

  assign r_o = r_q;
  assign g_o = g_q;
  assign b_o = b_q;

endmodule

// File: rtl/rgb_pwm_array.sv
// rgb_pwm_array: NUM_CH-channel RGB LED PWM driver. Owns the prescaler, the
// shared PWM counter, period_start, write decode/error and (with the macro
// RGB_PWM_BREATHE_EN defined) the triangular breathing envelope; each LED is
// handled by an rgb_pwm_channel instance.
module rgb_pwm_array
  import rgb_pwm_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int PWM_W        = 6,
  parameter int PRESCALE     = 1,
  parameter int BREATHE_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [15:0]       wr_color,
`ifdef RGB_PWM_BREATHE_EN
  input  logic              breathe_on,
`endif
  output logic              wr_err,
  output logic              period_start,
  output logic [NUM_CH-1:0] rLED,
  output logic [NUM_CH-1:0] gLED,
  output logic [NUM_CH-1:0] bLED
);

  localparam int               MAX      = pwm_max(PWM_W);
  localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'(MAX - 1);
  localparam int               PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic             ps_q, err_q;
  logic             tick, boundary, load, err_d;

  // Prescaler and PWM counter advance; both sit at 0 while disabled.
  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    tick     = enable && (presc_q == PS_LAST);
    boundary = tick && (cnt_q == CNT_LAST);
    if (!enable) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      cnt_d   = boundary ? '0 : cnt_q + PWM_W'(1);
    end else begin
      presc_d = presc_q + PS_W'(1);
    end
  end

  // Active duty reloads at each period boundary, and continuously while disabled.
  assign load  = boundary || !enable;
  assign err_d = wr_en && ({1'b0, wr_ch} >= 5'(NUM_CH));

  // Counter, period_start pulse and write-error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      ps_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      ps_q    <= boundary;
      err_q   <= err_d;
    end
  end

  assign period_start = ps_q;
  assign wr_err       = err_q;

`ifdef RGB_PWM_BREATHE_EN
  localparam int              BS_W    = (BREATHE_STEP > 1) ? $clog2(BREATHE_STEP) : 1;
  localparam logic [BS_W-1:0] BS_LAST = BS_W'(BREATHE_STEP - 1);

  logic [PWM_W-1:0] env_q, env_d;
  env_dir_e         dir_q, dir_d;
  logic [BS_W-1:0]  bstep_q, bstep_d;

  // Envelope steps once every BREATHE_STEP boundaries, bouncing between 0 and MAX.
  always_comb begin
    env_d   = env_q;
    dir_d   = dir_q;
    bstep_d = bstep_q;
    if (boundary) begin
      if (bstep_q == BS_LAST) begin
        bstep_d = '0;
        if (dir_q == ENV_UP) begin
          env_d = env_q + PWM_W'(1);
          if (env_q == CNT_LAST) dir_d = ENV_DOWN;
        end else begin
          env_d = env_q - PWM_W'(1);
          if (env_q == PWM_W'(1)) dir_d = ENV_UP;
        end
      end else begin
        bstep_d = bstep_q + BS_W'(1);
      end
    end
  end

  // Envelope state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      env_q   <= '0;
      dir_q   <= ENV_UP;
      bstep_q <= '0;
    end else begin
      env_q   <= env_d;
      dir_q   <= dir_d;
      bstep_q <= bstep_d;
    end
  end
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rgb_pwm_channel #(
      .PWM_W (PWM_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .enable_i   (enable),
      .wr_en_i    (wr_en && (wr_ch == 4'(c))),
      .wr_color_i (wr_color),
      .load_i     (load),
      .cnt_i      (cnt_q),
`ifdef RGB_PWM_BREATHE_EN
      .scale_en_i (breathe_on),
      .env_i      (env_q),
`endif
      .r_o        (rLED[c]),
      .g_o        (gLED[c]),
      .b_o        (bLED[c])
    );
  end

endmodule

// File: doc/rgb_pwm_array.md
# rgb_pwm_array

Parametrised multi-channel RGB LED PWM driver. It drives NUM_CH RGB LEDs from per-channel RGB565 colour words, loaded through a write port, and generalises the single-LED, switch-driven PWM generator to configurable channel count, PWM resolution and tick rate. It uses glitch-free shadow-register updates and an optional breathing envelope. It sits between the board register/switch logic and the RGB LED pins.

## Interface
- NUM_CH, 4: number of RGB channels (1..16)
- PWM_W, 6: PWM resolution in bits (6..10); MAX = 2^PWM_W − 1
- PRESCALE, 1: clk cycles per PWM count (≥1)
- BREATHE_STEP, 4: PWM periods per envelope step (≥1; used only with RGB_PWM_BREATHE_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run PWM; 0 forces all LEDs off
- wr_en  in  1  colour write strobe (single-cycle; always accepted)
- wr_ch  in  4  target channel index
- wr_color  in  16  RGB565: R=[15:11], G=[10:5], B=[4:0]
- wr_err  out  1  one-cycle pulse: write with wr_ch ≥ NUM_CH (write dropped)
- period_start  out  1  one-cycle pulse at each PWM period boundary
- rLED, gLED, bLED  out  NUM_CH  per-channel LED drives, registered

## Operation
- Colour expansion to PWM_W bits: left-justify the k-bit field (k=5 R/B, k=6 G) and fill the low PWM_W−k bits with the field's top PWM_W−k bits. Examples at PWM_W=6: R=5'b11111→63; R=5'b00001→2.
- Per channel: pending reg (written by port), active duty reg (used by comparator).
- Write: the cycle wr_en=1 with a valid wr_ch sets pending[wr_ch] <= wr_color; active is unaffected.
- Prescaler counts 0..PRESCALE−1; a tick occurs at the wrap. The PWM counter cnt advances on a tick over 0..MAX−1, then wraps to 0.
- Boundary (tick with cnt=MAX−1 → 0): period_start=1, and every active <= expand(pending) using the pre-write pending value. A write landing in the same cycle takes effect next period.
- Output: LED <= (cnt < duty) per colour. duty=0 is always off; duty=MAX is always on.
- enable=0: prescaler and cnt held at 0, all LEDs 0, active reloaded from pending every cycle, no period_start. After enable rises, the first period uses the latest pending.
- Reset: pending, active, cnt, prescaler = 0; all outputs 0; envelope 0, direction up.

## Timing
- LED outputs lag the cnt compare by 1 cycle. The first output of a new period appears the cycle after period_start.
- Period length = MAX × PRESCALE clk cycles.
- Write-to-visible latency: up to one full period, plus 1 cycle.
- wr_err is asserted the cycle after the bad write.
- rst mid-period: all outputs 0 the next cycle, and all state cleared.

## Configuration
- RGB_PWM_BREATHE_EN defined:
  - Adds input breathe_on (1 bit) and a global envelope env (PWM_W bits) that triangles 0→MAX→0.
  - env steps ±1 at every BREATHE_STEP-th period boundary. Direction flips on reaching MAX or 0.
  - When breathe_on=1, active duty = (duty × env) >> PWM_W, computed at load. When breathe_on=0, duty is unscaled and env keeps running.
- Undefined: no breathe_on port, no envelope logic; duty is always unscaled.

## Structure
- Package rgb_pwm_pkg holds:
  - RGB565 field position/width constants
  - expansion function
  - MAX computation helper
  - envelope direction enum
- Sub-module rgb_pwm_channel, one instance per channel: pending/active regs, expansion, three comparators, output regs. The top module owns the prescaler, cnt, period_start, envelope and write decode.

## Test plan
Bench parameters: NUM_CH=3, PWM_W=6, PRESCALE=1, enable=1 unless stated.

- Write ch0=16'hF800 → after the next period_start, rLED[0]=1 for all 63 cycles; gLED[0]=bLED[0]=0.
- Write ch1=16'h0400 (G=32) → gLED[1] high for 32 of every 63 cycles. Write ch2=16'h0800 (R=1) → rLED[2] high for exactly 2 cycles per period.
- Write ch0=16'h001F mid-period → bLED[0] unchanged until the next period_start, then high for all 63 cycles. Write in the same cycle as period_start → visible only one period later.
- wr_ch=3 → wr_err pulses once; all channels unchanged. Deassert enable → all LEDs 0 the next cycle and period_start stops.
- Assert rst mid-period with all channels lit → all outputs 0 the next cycle. After release, LEDs stay dark until new writes.
- With RGB_PWM_BREATHE_EN and BREATHE_STEP=1, breathe_on=1, ch0=16'hF800 → rLED[0] high-time per period ramps 0,0,…,62 over 63 periods, then ramps back down.
